router_fsm_nch: RTL and testbench
=================================

// Module: router_fsm_nch
// PURPOSE
// Parametrised control FSM for a 1xN packet router: 1 input port, NUM_CH output FIFOs.
// Decodes header address, sequences header/payload/parity writes, and handles full-FIFO stalls.
// Adds invalid-address packet drop and a wait-till-empty timeout.
// Sits between the input register block and the FIFO/synchroniser blocks.
// PARAMETERS
// NUM_CH        3   number of output channels (2..16)
// ADDR_W        2   header address width; must be >= clog2(NUM_CH)
// WAIT_TIMEOUT  0   max cycles in WAIT_TILL_EMPTY before drop; 0 = wait forever
// PORTS
// clock          in   1        system clock, rising edge
// resetn         in   1        asynchronous active-low reset
// pkt_valid      in   1        input packet valid (high for header+payload)
// data_in        in   ADDR_W   header address bits, sampled in DECODE_ADDRESS
// fifo_full      in   1        selected output FIFO full
// fifo_empty     in   NUM_CH   per-channel FIFO empty
// soft_reset     in   NUM_CH   per-channel soft reset from synchroniser
// parity_done    in   1        parity byte already written (from register block)
// low_pkt_valid  in   1        pkt_valid fell while in a full stall
// sel_ch         out  ADDR_W   latched destination channel
// busy           out  1        stall input source
// detect_add     out  1        state == DECODE_ADDRESS
// lfd_state      out  1        state == LOAD_FIRST_DATA
// ld_state       out  1        state == LOAD_DATA
// laf_state      out  1        state == LOAD_AFTER_FULL
// full_state     out  1        state == FIFO_FULL_STATE
// write_enb_reg  out  1        FIFO write enable: LD | LOAD_PARITY | LAF
// rst_int_reg    out  1        state == CHECK_PARITY_ERROR
// drop_state     out  1        state == DROP_PACKET
// timeout_pulse  out  1        one-cycle pulse on WAIT_TILL_EMPTY timeout
// BEHAVIOUR
// - Moore FSM. All outputs except timeout_pulse decode from the state register.
// - Reset: state=DA, detect_add=1, all other outputs 0, sel_ch=0, wait counter=0.
// - busy = LFD | LP | FFS | LAF | WTE | CPE; busy=0 in DA, LD and DROP.
// - DA: pkt_valid=0 -> DA. On pkt_valid=1, sel_ch<=data_in, then:
//     data_in>=NUM_CH -> DROP; fifo_empty[data_in] -> LFD; otherwise -> WTE.
// - LFD -> LD, unconditionally.
// - LD: fifo_full -> FFS; else !pkt_valid -> LP; else LD.
// - FFS: fifo_full -> FFS; else LAF.
// - LAF: parity_done -> DA; else low_pkt_valid -> LP; else LD.
// - LP -> CPE. CPE: fifo_full -> FFS; else DA.
// - WTE: fifo_empty[sel_ch] -> LFD. Else, if WAIT_TIMEOUT!=0 and the counter reaches
//   WAIT_TIMEOUT-1 -> DROP, with timeout_pulse=1 for that cycle. Else increment counter.
//   Counter clears on entry to WTE.
// - DROP: discard input, no writes. !pkt_valid -> DA; else DROP.
// - Soft reset: soft_reset[sel_ch]=1 in any state except DA -> DA next cycle.
//   Overrides all other transitions. Ignored in DA.
// - fifo_full and fifo_empty bits for unselected channels are don't-care outside DA/WTE.
// - Async reset mid-packet returns to DA immediately; no partial-state recovery.
// TESTING
// 1 Normal: DA, pkt_valid=1, data_in=0, fifo_empty=3'b001 -> LFD, LD; pkt_valid=0 -> LP, CPE, DA.
//   write_enb_reg=1 in LD and LP.
// 2 Full stall: in LD set fifo_full=1 -> FFS with busy=1; fifo_full=0 -> LAF;
//   parity_done=0, low_pkt_valid=1 -> LP -> CPE -> DA.
// 3 Stall resume: FFS -> LAF with low_pkt_valid=0 and parity_done=0 -> LD.
//   Then pkt_valid=0 -> LP -> CPE -> DA.
// 4 Wait/timeout: WAIT_TIMEOUT=4, data_in=2, fifo_empty[2]=0 -> WTE, busy=1 for 4 cycles,
//   timeout_pulse once, then DROP. pkt_valid=0 -> DA.
// 5 Invalid address: NUM_CH=3, data_in=3 -> DROP, busy=0, write_enb_reg=0. pkt_valid=0 -> DA.
// 6 Soft reset: in LD with sel_ch=1, pulse soft_reset[1] -> DA next cycle.
//   soft_reset[0] pulse is ignored. resetn=0 asserted in FFS -> DA immediately.

Source files
------------

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: control FSM for a 1xN packet router with invalid-address drop and wait timeout
// Ports:
//   clock, resetn                    rising-edge clock, asynchronous active-low reset
//   pkt_valid, data_in               packet framing and header address (sampled in DECODE_ADDRESS)
//   fifo_full, fifo_empty            selected-FIFO full flag and per-channel empty flags
//   soft_reset                       per-channel soft reset; only the selected channel matters
//   parity_done, low_pkt_valid       status from the input register block
//   sel_ch                           latched destination channel
//   busy                             stall request to the input source
//   detect_add .. drop_state         registered one-hot state decodes
//   write_enb_reg, rst_int_reg       FIFO write enable and parity-check strobe
//   timeout_pulse                    single-cycle pulse when WAIT_TILL_EMPTY gives up
module router_fsm_nch #(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic [ADDR_W-1:0] sel_ch,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              drop_state,
    output logic              timeout_pulse
);
    typedef enum logic [3:0] {DA, LFD, LD, FFS, LAF, LP, CPE, WTE, DROP} state_t;
    localparam logic [ADDR_W:0] NCH = (ADDR_W+1)'(NUM_CH);
    state_t state, next;
    logic [31:0] wait_cnt;
    logic empty_in, empty_sel, sr_sel, bad_addr, timed_out;
    always_comb begin
        empty_in  = 1'b0;
        empty_sel = 1'b0;
        sr_sel    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (data_in == ADDR_W'(i)) empty_in = fifo_empty[i];
            if (sel_ch == ADDR_W'(i)) begin
                empty_sel = fifo_empty[i];
                sr_sel    = soft_reset[i];
            end
        end
        bad_addr  = {1'b0, data_in} >= NCH;
        timed_out = (WAIT_TIMEOUT != 0) && state == WTE && !empty_sel
                    && wait_cnt == 32'(WAIT_TIMEOUT - 1);
        case (state)
            DA:      next = !pkt_valid ? DA : bad_addr ? DROP : empty_in ? LFD : WTE;
            LFD:     next = LD;
            LD:      next = fifo_full ? FFS : !pkt_valid ? LP : LD;
            FFS:     next = fifo_full ? FFS : LAF;
            LAF:     next = parity_done ? DA : low_pkt_valid ? LP : LD;
            LP:      next = CPE;
            CPE:     next = fifo_full ? FFS : DA;
            WTE:     next = empty_sel ? LFD : timed_out ? DROP : WTE;
            DROP:    next = pkt_valid ? DROP : DA;
            default: next = DA;
        endcase
        // a soft reset of the active channel aborts the packet from any state but DA
        if (state != DA && sr_sel) next = DA;
        timeout_pulse = timed_out && !sr_sel;
    end
    // outputs are registered from the next state so they always match the state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= DA;
            sel_ch        <= '0;
            wait_cnt      <= '0;
            busy          <= 1'b0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            write_enb_reg <= 1'b0;
            rst_int_reg   <= 1'b0;
            drop_state    <= 1'b0;
        end else begin
            state         <= next;
            if (state == DA && pkt_valid) sel_ch <= data_in;
            wait_cnt      <= (state == WTE && next == WTE) ? wait_cnt + 32'd1 : '0;
            busy          <= next inside {LFD, LP, FFS, LAF, WTE, CPE};
            detect_add    <= next == DA;
            lfd_state     <= next == LFD;
            ld_state      <= next == LD;
            laf_state     <= next == LAF;
            full_state    <= next == FFS;
            write_enb_reg <= next inside {LD, LP, LAF};
            rst_int_reg   <= next == CPE;
            drop_state    <= next == DROP;
        end
    end
endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: scoreboard bench for router_fsm_nch with directed packet scenarios
module tb_router_fsm_nch;
    localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_FFS = 3, S_LAF = 4, S_LP = 5, S_CPE = 6, S_WTE = 7, S_DROP = 8;
    logic clock = 1'b0, resetn = 1'b0, pkt_valid = 1'b0, fifo_full = 1'b0, parity_done = 1'b0, low_pkt_valid = 1'b0;
    logic [1:0] data_in = '0, sel_ch;
    logic [2:0] fifo_empty = '0, soft_reset = '0;
    logic busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, drop_state, timeout_pulse;
    logic [10:0] q[$];
    logic [10:0] got, e;
    int compared = 0, mism = 0, pulse_cnt = 0, idx = 0;
    logic end_req = 1'b0, end_done = 1'b0;
    router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(4)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .sel_ch(sel_ch),
        .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .drop_state(drop_state), .timeout_pulse(timeout_pulse)
    );
    always #5 clock = ~clock;
    function automatic logic [10:0] mk(input int st, input logic [1:0] sel);
        return {sel, st == S_LFD || st == S_LP || st == S_FFS || st == S_LAF || st == S_WTE || st == S_CPE,
                st == S_DA, st == S_LFD, st == S_LD, st == S_LAF, st == S_FFS,
                st == S_LD || st == S_LP || st == S_LAF, st == S_CPE, st == S_DROP};
    endfunction
    always @(negedge clock) begin
        got = {sel_ch, busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, drop_state};
        if (timeout_pulse) pulse_cnt++;
        if (q.size() > 0) begin
            e = q.pop_front();
            compared++;
            idx++;
            if (got !== e) begin
                mism++;
                $display("FAIL outputs#%0d {sel,busy,da,lfd,ld,laf,ffs,we,cpe,drop}: got %b expected %b", idx, got, e);
            end
        end
        if (end_req && !end_done) begin
            compared++;
            if (pulse_cnt != 1) begin
                mism++;
                $display("FAIL timeout_pulse_count: got %0d expected 1", pulse_cnt);
            end
            compared++;
            if (q.size() != 0) begin
                mism++;
                $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
            end
            end_done = 1'b1;
        end
    end
    task automatic step(input logic pv, input logic [1:0] din, input logic ff, input logic [2:0] fe,
                        input logic [2:0] sr, input logic pd, input logic lpv, input int st, input logic [1:0] sel);
        pkt_valid = pv; data_in = din; fifo_full = ff; fifo_empty = fe;
        soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
        @(posedge clock);
        #1 q.push_back(mk(st, sel));
    endtask
    initial begin
        q.push_back(mk(S_DA, 2'd0));
        @(negedge clock);
        #1 resetn = 1'b1;
        // normal packet to channel 0
        step(1, 0, 0, 3'b001, 0, 0, 0, S_LFD, 0);
        step(1, 0, 0, 3'b001, 0, 0, 0, S_LD, 0);
        step(1, 0, 0, 3'b001, 0, 0, 0, S_LD, 0);
        step(0, 0, 0, 3'b001, 0, 0, 0, S_LP, 0);
        step(0, 0, 0, 3'b001, 0, 0, 0, S_CPE, 0);
        step(0, 0, 0, 3'b001, 0, 0, 0, S_DA, 0);
        // full stall ending with low_pkt_valid
        step(1, 0, 0, 3'b001, 0, 0, 0, S_LFD, 0);
        step(1, 0, 0, 3'b001, 0, 0, 0, S_LD, 0);
        step(1, 0, 1, 3'b001, 0, 0, 0, S_FFS, 0);
        step(1, 0, 1, 3'b001, 0, 0, 0, S_FFS, 0);
        step(0, 0, 0, 3'b001, 0, 0, 1, S_LAF, 0);
        step(0, 0, 0, 3'b001, 0, 0, 1, S_LP, 0);
        step(0, 0, 0, 3'b001, 0, 0, 0, S_CPE, 0);
        step(0, 0, 0, 3'b001, 0, 0, 0, S_DA, 0);
        // stall resume back into LOAD_DATA
        step(1, 0, 0, 3'b001, 0, 0, 0, S_LFD, 0);
        step(1, 0, 0, 3'b001, 0, 0, 0, S_LD, 0);
        step(1, 0, 1, 3'b001, 0, 0, 0, S_FFS, 0);
        step(1, 0, 0, 3'b001, 0, 0, 0, S_LAF, 0);
        step(1, 0, 0, 3'b001, 0, 0, 0, S_LD, 0);
        step(0, 0, 0, 3'b001, 0, 0, 0, S_LP, 0);
        step(0, 0, 0, 3'b001, 0, 0, 0, S_CPE, 0);
        step(0, 0, 0, 3'b001, 0, 0, 0, S_DA, 0);
        // channel 2 never drains: four cycles of WTE then drop
        step(1, 2, 0, 3'b011, 0, 0, 0, S_WTE, 2);
        step(1, 2, 0, 3'b011, 0, 0, 0, S_WTE, 2);
        step(1, 2, 0, 3'b011, 0, 0, 0, S_WTE, 2);
        step(1, 2, 0, 3'b011, 0, 0, 0, S_WTE, 2);
        step(1, 2, 0, 3'b011, 0, 0, 0, S_DROP, 2);
        step(1, 2, 0, 3'b011, 0, 0, 0, S_DROP, 2);
        step(0, 2, 0, 3'b011, 0, 0, 0, S_DA, 2);
        // invalid address 3
        step(1, 3, 0, 3'b111, 0, 0, 0, S_DROP, 3);
        step(1, 3, 0, 3'b111, 0, 0, 0, S_DROP, 3);
        step(0, 3, 0, 3'b111, 0, 0, 0, S_DA, 3);
        // channel 1 waits once, drains, then soft resets
        step(1, 1, 0, 3'b101, 0, 0, 0, S_WTE, 1);
        step(1, 1, 0, 3'b111, 0, 0, 0, S_LFD, 1);
        step(1, 1, 0, 3'b111, 0, 0, 0, S_LD, 1);
        step(1, 1, 0, 3'b111, 3'b001, 0, 0, S_LD, 1);
        step(1, 1, 0, 3'b111, 3'b010, 0, 0, S_DA, 1);
        step(0, 1, 0, 3'b111, 0, 0, 0, S_DA, 1);
        // asynchronous reset while stalled in FFS
        step(1, 0, 0, 3'b001, 0, 0, 0, S_LFD, 0);
        step(1, 0, 0, 3'b001, 0, 0, 0, S_LD, 0);
        step(1, 0, 1, 3'b001, 0, 0, 0, S_FFS, 0);
        @(negedge clock);
        #1 pkt_valid = 1'b0;
        resetn = 1'b0;
        #2 resetn = 1'b1;
        q.push_back(mk(S_DA, 0));
        @(posedge clock);
        #1 step(0, 0, 0, 3'b001, 0, 0, 0, S_DA, 0);
        end_req = 1'b1;
        for (int i = 0; i < 20 && !end_done; i++) @(negedge clock);
        if (!end_done) begin
            $display("FAIL monitor_finish: got no completion expected completion");
            $fatal(1);
        end
        #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
